gpio_led_fsm: RTL and testbench

- Free-running LED pattern sequencer driving the 8 board GPIO LEDs.
- A prescaler divides the clock into "step" ticks.
- A 4-state FSM cycles through the patterns walk-left, walk-right, blink and bar-fill, then repeats forever.
- Standalone leaf block with no inputs besides clock and reset; it sits directly at the board LED pins.

---
 rtl/gpio_led_fsm_pkg.sv | 67 ++++++
 rtl/gpio_led_tick_gen.sv | 29 ++
 rtl/gpio_led_fsm.sv | 66 ++++++
 tb/tb_gpio_led_fsm.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/gpio_led_fsm_pkg.sv
// Shared types, constants and the pattern function for the GPIO LED
// sequencer. When GPIO_LED_ACTIVE_LOW_EN is defined, every pattern and the
// LED reset value are inverted for boards with active-low LEDs.
package gpio_led_fsm_pkg;

  typedef enum logic [1:0] {
    WALK_L = 2'd0,
    WALK_R = 2'd1,
    BLINK  = 2'd2,
    FILL   = 2'd3
  } state_t;

  // Index of the final step of each state before moving on
  localparam logic [2:0] LAST_WALK_L = 3'd7;
  localparam logic [2:0] LAST_WALK_R = 3'd7;
  localparam logic [2:0] LAST_BLINK  = 3'd3;
  localparam logic [2:0] LAST_FILL   = 3'd7;

`ifdef GPIO_LED_ACTIVE_LOW_EN
  localparam logic       LED_ACTIVE_LOW = 1'b1;
  localparam logic [7:0] LED_RESET      = 8'hFF;
`else
  localparam logic       LED_ACTIVE_LOW = 1'b0;
  localparam logic [7:0] LED_RESET      = 8'h00;
`endif

  // Final step index for the given state
  function automatic logic [2:0] last_idx(state_t s);
    logic [2:0] last;
    case (s)
      WALK_L:  last = LAST_WALK_L;
      WALK_R:  last = LAST_WALK_R;
      BLINK:   last = LAST_BLINK;
      FILL:    last = LAST_FILL;
      default: last = 3'd0;
    endcase
    return last;
  endfunction

  // State that follows the given one once its last step has been shown
  function automatic state_t next_state_of(state_t s);
    state_t nxt;
    case (s)
      WALK_L:  nxt = WALK_R;
      WALK_R:  nxt = BLINK;
      BLINK:   nxt = FILL;
      FILL:    nxt = WALK_L;
      default: nxt = WALK_L;
    endcase
    return nxt;
  endfunction

  // LED drive value for a given state and step, already polarity-adjusted.
  // FILL wraps naturally at idx 7: 8'h02<<7 is 8'h00, minus one gives 8'hFF.
  function automatic logic [7:0] pattern(state_t s, logic [2:0] idx);
    logic [7:0] raw;
    case (s)
      WALK_L:  raw = 8'h01 << idx;
      WALK_R:  raw = 8'h80 >> idx;
      BLINK:   raw = idx[0] ? 8'h00 : 8'hFF;
      FILL:    raw = (8'h02 << idx) - 8'h01;
      default: raw = 8'h00;
    endcase
    return LED_ACTIVE_LOW ? ~raw : raw;
  endfunction

endpackage

// File: rtl/gpio_led_tick_gen.sv
// Prescaler for the LED sequencer: counts 0..TICK_DIV-1 and raises a
// one-cycle step tick on the final count. TICK_DIV=1 ticks every cycle.
module gpio_led_tick_gen #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] TERMINAL = CW'(TICK_DIV - 1);

  logic [CW-1:0] count;

  assign tick = (count == TERMINAL);

  // Free-running divider that wraps to zero on the tick cycle
  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/gpio_led_fsm.sv
// Free-running LED pattern sequencer: walk-left, walk-right, blink,
// bar-fill, repeat. Each step is held for TICK_DIV clocks and the LED
// output is registered one cycle behind the state/index.
// Optional macro GPIO_LED_ACTIVE_LOW_EN inverts all LED values.
module gpio_led_fsm
  import gpio_led_fsm_pkg::*;
#(
  parameter int TICK_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  output logic [7:0] GPIO_LED
);

  state_t     state;
  state_t     next_state;
  logic [2:0] idx;
  logic [2:0] next_idx;
  logic [7:0] next_led;
  logic       tick;

  gpio_led_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .reset(reset),
    .tick (tick)
  );

  // State, step index and LED output register with synchronous reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= WALK_L;
      idx      <= 3'd0;
      GPIO_LED <= LED_RESET;
    end else begin
      state    <= next_state;
      idx      <= next_idx;
      GPIO_LED <= next_led;
    end
  end

  // Step advance on tick, state hand-off after the last step, illegal recovery
  always_comb begin
    next_state = state;
    next_idx   = idx;
    next_led   = pattern(state, idx);
    case (state)
      WALK_L, WALK_R, BLINK, FILL: begin
        if (tick) begin
          if (idx == last_idx(state)) begin
            next_idx   = 3'd0;
            next_state = next_state_of(state);
          end else begin
            next_idx = idx + 3'd1;
          end
        end
      end
      default: begin
        next_state = WALK_L;
        next_idx   = 3'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_gpio_led_fsm.sv
// Testbench for gpio_led_fsm: one instance at TICK_DIV=4 and one at
// TICK_DIV=1 share clock and reset. A sequence-table model predicts the
// LEDs every cycle; literal checks pin key edges. Honours
// GPIO_LED_ACTIVE_LOW_EN the same way as the design.
module tb_gpio_led_fsm;

  logic       clk;
  logic       reset;
  logic [7:0] led4;
  logic [7:0] led1;

  int checks = 0;
  int errors = 0;

  logic [7:0] seq [28];
  int         k;
  int         e;
  logic       valid;
  logic [7:0] exp4;
  logic [7:0] exp1;

  gpio_led_fsm #(.TICK_DIV(4)) dut4 (
    .clk     (clk),
    .reset   (reset),
    .GPIO_LED(led4)
  );

  gpio_led_fsm #(.TICK_DIV(1)) dut1 (
    .clk     (clk),
    .reset   (reset),
    .GPIO_LED(led1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply board polarity to an active-high pattern
  function automatic logic [7:0] lv(logic [7:0] v);
`ifdef GPIO_LED_ACTIVE_LOW_EN
    return ~v;
`else
    return v;
`endif
  endfunction

  task automatic checkOutput(string name, logic [7:0] actual, logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Advance to the negedge following release-relative edge `target`
  task automatic applyStimulus(int target);
    while (e < target) begin
      @(negedge clk);
      e++;
    end
  endtask

  // Model: edge count since release picks the step from the 28-entry loop
  always @(posedge clk) begin
    if (!reset) begin
      k    = 0;
      exp4 = lv(8'h00);
      exp1 = lv(8'h00);
    end else begin
      k    = k + 1;
      exp4 = lv(seq[((k - 1) / 4) % 28]);
      exp1 = lv(seq[(k - 1) % 28]);
    end
    valid = 1'b1;
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (valid) begin
      checkOutput("model_div4", led4, exp4);
      checkOutput("model_div1", led1, exp1);
    end
  end

  initial begin
    valid = 1'b0;
    k     = 0;
    e     = 0;
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      seq[i]      = 8'(1 << i);
      seq[8 + i]  = 8'(128 >> i);
      seq[20 + i] = 8'((2 << i) - 1);
    end
    seq[16] = 8'hFF;
    seq[17] = 8'h00;
    seq[18] = 8'hFF;
    seq[19] = 8'h00;

    checkOutput("table_step0", seq[0], 8'h01);
    checkOutput("table_step15", seq[15], 8'h01);
    checkOutput("table_step21", seq[21], 8'h03);

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("reset_hold", led4, lv(8'h00));
    end
    reset = 1'b1;
    e = 0;

    applyStimulus(1);   checkOutput("d4_edge1", led4, lv(8'h01));
                        checkOutput("d1_edge1", led1, lv(8'h01));
    applyStimulus(2);   checkOutput("d1_edge2", led1, lv(8'h02));
    applyStimulus(4);   checkOutput("d4_edge4", led4, lv(8'h01));
    applyStimulus(5);   checkOutput("d4_edge5", led4, lv(8'h02));
    applyStimulus(17);  checkOutput("d1_blink", led1, lv(8'hFF));
    applyStimulus(28);  checkOutput("d1_loop_end", led1, lv(8'hFF));
    applyStimulus(29);  checkOutput("d1_loop_wrap", led1, lv(8'h01));
    applyStimulus(32);  checkOutput("d4_edge32", led4, lv(8'h80));
    applyStimulus(33);  checkOutput("d4_walkr0", led4, lv(8'h80));
    applyStimulus(37);  checkOutput("d4_walkr1", led4, lv(8'h40));
    applyStimulus(69);  checkOutput("d4_blink_off", led4, lv(8'h00));
    applyStimulus(81);  checkOutput("d4_fill0", led4, lv(8'h01));
    applyStimulus(112); checkOutput("d4_fill7", led4, lv(8'hFF));
    applyStimulus(113); checkOutput("d4_loop_wrap", led4, lv(8'h01));
    applyStimulus(183); checkOutput("d4_blink_again", led4, lv(8'h00));

    reset = 1'b0;
    @(negedge clk);
    checkOutput("midrun_reset_d4", led4, lv(8'h00));
    checkOutput("midrun_reset_d1", led1, lv(8'h00));
    reset = 1'b1;
    e = 0;
    applyStimulus(1);   checkOutput("restart_d4", led4, lv(8'h01));
                        checkOutput("restart_d1", led1, lv(8'h01));
    applyStimulus(5);   checkOutput("restart_d4_step1", led4, lv(8'h02));
    applyStimulus(197); checkOutput("d1_seventh_loop", led1, lv(8'h01));
    applyStimulus(200);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
